// File: rtl/palette_scanout_if.sv
// Scanout bus between palette_scanout and its environment (hdmi timing,
// framebuffer RAM, palette RAM). The scanout engine takes the master side.
interface palette_scanout_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [11:0]           cx;
    logic [11:0]           cy;
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic                  fb_rden;
    logic [7:0]            fb_data;
    logic [7:0]            pal_addr;
    logic [23:0]           pal_data;
    logic [23:0]           rgb;
    logic                  active;
    logic                  frame_start;

    modport master (
        input  cx, cy, fb_data, pal_data,
        output fb_addr, fb_rden, pal_addr, rgb, active, frame_start
    );

    modport slave (
        output cx, cy, fb_data, pal_data,
        input  fb_addr, fb_rden, pal_addr, rgb, active, frame_start
    );
endinterface

// File: rtl/palette_scanout.sv
// Indexed-colour scanout: 1/2/4/8 bpp unpack, integer upscale into a centred
// window, fixed 4-cycle latency. PALETTE_SCANOUT_BORDER_EN adds border_rgb.
module palette_scanout #(
    parameter int BPP           = 8,
    parameter int FB_WIDTH      = 320,
    parameter int FB_HEIGHT     = 240,
    parameter int SCALE_X       = 4,
    parameter int SCALE_Y       = 4,
    parameter int SCREEN_WIDTH  = 1920,
    parameter int SCREEN_HEIGHT = 1080,
    parameter int ADDR_WIDTH    = 17
) (
    input  logic        clk_pixel,
    input  logic        reset,
`ifdef PALETTE_SCANOUT_BORDER_EN
    input  logic [23:0] border_rgb,
`endif
    palette_scanout_if.master bus
);
    localparam int PPB   = 8 / BPP;
    localparam int WIN_W = FB_WIDTH * SCALE_X;
    localparam int WIN_H = FB_HEIGHT * SCALE_Y;
    localparam int X0_I  = (SCREEN_WIDTH - WIN_W) / 2;
    localparam int Y0_I  = (SCREEN_HEIGHT - WIN_H) / 2;

    localparam logic [11:0] X0     = 12'(X0_I);
    localparam logic [11:0] X1     = 12'(X0_I + WIN_W);
    localparam logic [11:0] Y0     = 12'(Y0_I);
    localparam logic [11:0] Y1     = 12'(Y0_I + WIN_H);
    localparam logic [11:0] X_LAST = 12'(SCREEN_WIDTH - 1);
    localparam logic [2:0]  SX_LAST = 3'(SCALE_X - 1);
    localparam logic [2:0]  SY_LAST = 3'(SCALE_Y - 1);
    localparam logic [2:0]  PX_LAST = 3'(PPB - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH / PPB);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    if (BPP != 1 && BPP != 2 && BPP != 4 && BPP != 8) begin : g_bad_bpp
        $error("palette_scanout: BPP must be 1, 2, 4 or 8");
    end
    if (SCALE_X < 1 || SCALE_X > 8 || SCALE_Y < 1 || SCALE_Y > 8) begin : g_bad_scale
        $error("palette_scanout: SCALE_X/SCALE_Y must be in 1..8");
    end
    if (WIN_W > SCREEN_WIDTH || WIN_H > SCREEN_HEIGHT) begin : g_bad_window
        $error("palette_scanout: scaled image exceeds the screen");
    end
    if ((FB_WIDTH % PPB) != 0) begin : g_bad_width
        $error("palette_scanout: FB_WIDTH must be a multiple of pixels per byte");
    end
    if (FB_HEIGHT * FB_WIDTH / PPB > 2 ** ADDR_WIDTH) begin : g_bad_addr
        $error("palette_scanout: framebuffer does not fit in ADDR_WIDTH");
    end

    // Position counters
    logic                  synced_q, synced_d;
    logic [2:0]            sx_q, sx_d, px_q, px_d, sy_q, sy_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d, row_base_q, row_base_d;
    // Pipeline
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic                  fb_rden_q, fb_rden_d, rden1_q, rden1_d;
    logic [2:0]            px0_q, px0_d, px1_q, px1_d;
    logic [3:0]            vld_q, vld_d, fs_q, fs_d;
    logic [7:0]            word_q, word_d, pal_addr_q, pal_addr_d;
    logic [23:0]           rgb_q, rgb_d;
    logic                  active_q, active_d, frame_start_q, frame_start_d;

    logic                  in_x, in_y, in_win, frame_top, line_start;
    logic [2:0]            cur_sx, cur_px;
    logic [ADDR_WIDTH-1:0] cur_col;
    logic [7:0]            byte_sel;
    logic [5:0]            rshift;
    logic [BPP-1:0]        pix;
    logic [23:0]           bg_rgb;

`ifdef PALETTE_SCANOUT_BORDER_EN
    // Border colour travels alongside the pixel so it lines up with cx/cy.
    logic [3:0][23:0] bdr_q, bdr_d;
    assign bdr_d  = {bdr_q[2:0], border_rgb};
    assign bg_rgb = bdr_q[3];
    always_ff @(posedge clk_pixel) begin
        if (reset) bdr_q <= '0;
        else       bdr_q <= bdr_d;
    end
`else
    assign bg_rgb = 24'h000000;
`endif

    always_comb begin
        in_x       = (bus.cx >= X0) && (bus.cx < X1);
        in_y       = (bus.cy >= Y0) && (bus.cy < Y1);
        in_win     = synced_q && in_x && in_y;
        frame_top  = (bus.cx == 12'd0) && (bus.cy == 12'd0);
        line_start = (bus.cx == X0);
        cur_sx     = line_start ? 3'd0 : sx_q;
        cur_px     = line_start ? 3'd0 : px_q;
        cur_col    = line_start ? '0 : col_q;

        synced_d   = synced_q | frame_top;
        sx_d       = sx_q;
        px_d       = px_q;
        col_d      = col_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;

        if (frame_top) begin
            sy_d       = 3'd0;
            row_base_d = '0;
        end
        if (in_win) begin
            sx_d  = cur_sx + 3'd1;
            px_d  = cur_px;
            col_d = cur_col;
            if (cur_sx == SX_LAST) begin
                sx_d = 3'd0;
                if (cur_px == PX_LAST) begin
                    px_d  = 3'd0;
                    col_d = cur_col + ONE_A;
                end else begin
                    px_d = cur_px + 3'd1;
                end
            end
        end
        if (synced_q && in_y && bus.cx == X_LAST) begin
            sy_d = sy_q + 3'd1;
            if (sy_q == SY_LAST) begin
                sy_d       = 3'd0;
                row_base_d = row_base_q + ROW_STEP;
            end
        end

        // Stage 0: address issue
        fb_addr_d = in_win ? (row_base_q + cur_col) : fb_addr_q;
        fb_rden_d = in_win && (cur_sx == 3'd0) && (cur_px == 3'd0);
        px0_d     = cur_px;
        // Stage 1: memory read in flight
        rden1_d   = fb_rden_q;
        px1_d     = px0_q;
        vld_d     = {vld_q[2:0], in_win};
        fs_d      = {fs_q[2:0], frame_top};

        // Stage 2: pixel bits [7 - px*BPP -: BPP], MSB first
        byte_sel   = rden1_q ? bus.fb_data : word_q;
        word_d     = byte_sel;
        rshift     = 6'(8 - BPP) - ({3'd0, px1_q} * 6'(BPP));
        pix        = BPP'(byte_sel >> rshift);
        pal_addr_d = vld_q[1] ? 8'(pix) : pal_addr_q;

        // Stage 4: colour out
        rgb_d         = vld_q[3] ? bus.pal_data : bg_rgb;
        active_d      = vld_q[3];
        frame_start_d = fs_q[3];
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            synced_q      <= 1'b0;
            sx_q          <= '0;
            px_q          <= '0;
            sy_q          <= '0;
            col_q         <= '0;
            row_base_q    <= '0;
            fb_addr_q     <= '0;
            fb_rden_q     <= 1'b0;
            rden1_q       <= 1'b0;
            px0_q         <= '0;
            px1_q         <= '0;
            vld_q         <= '0;
            fs_q          <= '0;
            word_q        <= '0;
            pal_addr_q    <= '0;
            rgb_q         <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            synced_q      <= synced_d;
            sx_q          <= sx_d;
            px_q          <= px_d;
            sy_q          <= sy_d;
            col_q         <= col_d;
            row_base_q    <= row_base_d;
            fb_addr_q     <= fb_addr_d;
            fb_rden_q     <= fb_rden_d;
            rden1_q       <= rden1_d;
            px0_q         <= px0_d;
            px1_q         <= px1_d;
            vld_q         <= vld_d;
            fs_q          <= fs_d;
            word_q        <= word_d;
            pal_addr_q    <= pal_addr_d;
            rgb_q         <= rgb_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.fb_addr     = fb_addr_q;
    assign bus.fb_rden     = fb_rden_q;
    assign bus.pal_addr    = pal_addr_q;
    assign bus.rgb         = rgb_q;
    assign bus.active      = active_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_palette_scanout.sv
// Directed bench for palette_scanout: default 8bpp 4x4 instance (a) and a
// 4bpp 1x1 instance (b). Outputs are logged per clock edge and checked after.
module tb_palette_scanout;
    localparam int LOGN = 8192;
`ifdef PALETTE_SCANOUT_BORDER_EN
    localparam logic [23:0] BG = 24'h123456;
`else
    localparam logic [23:0] BG = 24'h000000;
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    palette_scanout_if #(.ADDR_WIDTH(17)) bus_a ();
    palette_scanout_if #(.ADDR_WIDTH(17)) bus_b ();

    palette_scanout dut_a (
        .clk_pixel (clk),
        .reset     (reset),
`ifdef PALETTE_SCANOUT_BORDER_EN
        .border_rgb(BG),
`endif
        .bus       (bus_a)
    );

    palette_scanout #(.BPP(4), .SCALE_X(1), .SCALE_Y(1)) dut_b (
        .clk_pixel (clk),
        .reset     (reset),
`ifdef PALETTE_SCANOUT_BORDER_EN
        .border_rgb(BG),
`endif
        .bus       (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Memory models: framebuffer byte = address LSBs, palette[k] = {k,~k,k}.
    always @(posedge clk) begin
        if (bus_a.fb_rden) bus_a.fb_data <= bus_a.fb_addr[7:0];
        bus_a.pal_data <= {bus_a.pal_addr, ~bus_a.pal_addr, bus_a.pal_addr};
        if (bus_b.fb_rden) bus_b.fb_data <= (bus_b.fb_addr == 17'd0) ? 8'hA5 : bus_b.fb_addr[7:0];
        bus_b.pal_data <= {bus_b.pal_addr, ~bus_b.pal_addr, bus_b.pal_addr};
    end

    logic [23:0] la_rgb  [LOGN];
    logic        la_act  [LOGN];
    logic        la_fs   [LOGN];
    logic        la_rden [LOGN];
    logic [16:0] la_addr [LOGN];
    logic [7:0]  la_pal  [LOGN];
    logic [23:0] lb_rgb  [LOGN];
    logic        lb_fs   [LOGN];
    logic        lb_rden [LOGN];
    logic [7:0]  lb_pal  [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            la_rgb[cyc]  = bus_a.rgb;
            la_act[cyc]  = bus_a.active;
            la_fs[cyc]   = bus_a.frame_start;
            la_rden[cyc] = bus_a.fb_rden;
            la_addr[cyc] = bus_a.fb_addr;
            la_pal[cyc]  = bus_a.pal_addr;
            lb_rgb[cyc]  = bus_b.rgb;
            lb_fs[cyc]   = bus_b.frame_start;
            lb_rden[cyc] = bus_b.fb_rden;
            lb_pal[cyc]  = bus_b.pal_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drive cx/cy of one instance for the next edge; e = that edge's number.
    task automatic drive(input bit sel_b, input int x, input int y, output int e);
        @(negedge clk);
        if (sel_b) begin
            bus_b.cx = 12'(x);
            bus_b.cy = 12'(y);
        end else begin
            bus_a.cx = 12'(x);
            bus_a.cy = 12'(y);
        end
        e = cyc + 1;
    endtask

    int e, e_fsb, e800, e801, e802, e803;
    int e_fs, e319, e320, e64, e1596, e1599, e1600;
    int e_pre, e_rel, e_fs2, f320, f324;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus_a.cx = 12'd5;  bus_a.cy = 12'd5;
        bus_b.cx = 12'd5;  bus_b.cy = 12'd5;
        bus_a.fb_data = 8'h00; bus_a.pal_data = 24'h0;
        bus_b.fb_data = 8'h00; bus_b.pal_data = 24'h0;
        repeat (3) @(negedge clk);
        check("reset_rgb",      32'(bus_a.rgb),         32'h0);
        check("reset_active",   32'(bus_a.active),      32'h0);
        check("reset_fs",       32'(bus_a.frame_start), 32'h0);
        check("reset_rden",     32'(bus_a.fb_rden),     32'h0);
        check("reset_addr",     32'(bus_a.fb_addr),     32'h0);
        check("reset_pal_addr", 32'(bus_a.pal_addr),    32'h0);
        reset = 1'b0;

        // Instance b: 4bpp 1x1, window origin (800,420)
        drive(1'b1, 0, 0, e_fsb);
        drive(1'b1, 800, 420, e800);
        drive(1'b1, 801, 420, e801);
        drive(1'b1, 802, 420, e802);
        drive(1'b1, 803, 420, e803);
        drive(1'b1, 5, 5, e);

        // Instance a, frame 1
        drive(1'b0, 0, 0, e_fs);
        for (int x = 319; x <= 327; x++) begin
            drive(1'b0, x, 60, e);
            if (x == 319) e319 = e;
            if (x == 320) e320 = e;
        end
        drive(1'b0, 1919, 60, e);
        for (int y = 61; y <= 63; y++) drive(1'b0, 1919, y, e);
        drive(1'b0, 320, 64, e64);
        drive(1'b0, 1919, 64, e);
        for (int y = 65; y <= 1018; y++) drive(1'b0, 1919, y, e);
        for (int x = 320; x <= 1600; x++) begin
            drive(1'b0, x, 1019, e);
            if (x == 1596) e1596 = e;
            if (x == 1599) e1599 = e;
            if (x == 1600) e1600 = e;
        end
        drive(1'b0, 1919, 1019, e);

        // Frame 2 with reset in the middle of line 500
        drive(1'b0, 0, 0, e);
        for (int y = 60; y <= 499; y++) drive(1'b0, 1919, y, e);
        for (int x = 320; x <= 327; x++) begin
            drive(1'b0, x, 500, e);
            if (x == 320) e_pre = e;
        end
        for (int x = 328; x <= 345; x++) begin
            drive(1'b0, x, 500, e);
            reset = (x < 330);
            if (x == 330) e_rel = e;
        end
        for (int y = 501; y <= 510; y++) drive(1'b0, 1919, y, e);
        drive(1'b0, 0, 0, e_fs2);
        drive(1'b0, 5, 5, e);
        for (int x = 320; x <= 324; x++) begin
            drive(1'b0, x, 60, e);
            if (x == 320) f320 = e;
            if (x == 324) f324 = e;
        end
        drive(1'b0, 5, 5, e);
        repeat (8) @(negedge clk);

        // Instance b
        check("b_frame_start",  32'(lb_fs[e_fsb + 4]), 32'h1);
        check("b_rden_800",     32'(lb_rden[e800]),    32'h1);
        check("b_rden_801",     32'(lb_rden[e801]),    32'h0);
        check("b_rden_802",     32'(lb_rden[e802]),    32'h1);
        check("b_pal_800",      32'(lb_pal[e800 + 2]), 32'h0A);
        check("b_pal_801",      32'(lb_pal[e801 + 2]), 32'h05);
        check("b_pal_802",      32'(lb_pal[e802 + 2]), 32'h00);
        check("b_pal_803",      32'(lb_pal[e803 + 2]), 32'h01);
        check("b_rgb_800",      32'(lb_rgb[e800 + 4]), 32'h0AF50A);
        check("b_rgb_801",      32'(lb_rgb[e801 + 4]), 32'h05FA05);

        // Instance a, frame 1
        check("a_frame_start",      32'(la_fs[e_fs + 4]),  32'h1);
        check("a_frame_start_end",  32'(la_fs[e_fs + 5]),  32'h0);
        check("a_rgb_319",          32'(la_rgb[e319 + 4]), 32'(BG));
        check("a_active_319",       32'(la_act[e319 + 4]), 32'h0);
        check("a_rden_319",         32'(la_rden[e319]),    32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("a_rgb_%0d", 320 + k), 32'(la_rgb[e320 + k + 4]), 32'h00FF00);
            check($sformatf("a_active_%0d", 320 + k), 32'(la_act[e320 + k + 4]), 32'h1);
        end
        check("a_rgb_324",   32'(la_rgb[e320 + 8]), 32'h01FE01);
        for (int k = 0; k <= 4; k++)
            check($sformatf("a_rden_%0d", 320 + k), 32'(la_rden[e320 + k]), (k % 4 == 0) ? 32'h1 : 32'h0);
        check("a_addr_324",  32'(la_addr[e320 + 4]), 32'h1);
        check("a_addr_y64",  32'(la_addr[e64]),      32'd320);
        check("a_rden_y64",  32'(la_rden[e64]),      32'h1);
        check("a_rden_1596", 32'(la_rden[e1596]),    32'h1);
        check("a_addr_1596", 32'(la_addr[e1596]),    32'd76799);
        check("a_addr_1599", 32'(la_addr[e1599]),    32'd76799);
        check("a_rden_1599", 32'(la_rden[e1599]),    32'h0);
        check("a_pal_1599",  32'(la_pal[e1599 + 2]), 32'hFF);
        check("a_rgb_1599",  32'(la_rgb[e1599 + 4]), 32'hFF00FF);
        check("a_act_1599",  32'(la_act[e1599 + 4]), 32'h1);
        check("a_act_1600",  32'(la_act[e1600 + 4]), 32'h0);
        check("a_rgb_1600",  32'(la_rgb[e1600 + 4]), 32'(BG));

        // Reset mid-frame
        check("a_act_y500_pre", 32'(la_act[e_pre + 4]), 32'h1);
        for (int k = e_rel - 1; k < e_fs2; k++)
            check($sformatf("a_rden_post_reset_%0d", k - e_rel), 32'(la_rden[k]), 32'h0);
        for (int k = e_rel + 5; k < e_rel + 20; k++) begin
            check($sformatf("a_rgb_post_reset_%0d", k - e_rel), 32'(la_rgb[k]), 32'(BG));
            check($sformatf("a_act_post_reset_%0d", k - e_rel), 32'(la_act[k]), 32'h0);
        end
        check("a_fs2_before", 32'(la_fs[e_fs2 + 3]), 32'h0);
        check("a_fs2",        32'(la_fs[e_fs2 + 4]), 32'h1);
        check("a_f2_rden_320", 32'(la_rden[f320]),   32'h1);
        check("a_f2_rgb_320", 32'(la_rgb[f320 + 4]), 32'h00FF00);
        check("a_f2_act_320", 32'(la_act[f320 + 4]), 32'h1);
        check("a_f2_addr_324", 32'(la_addr[f324]),   32'h1);
        check("a_f2_rgb_324", 32'(la_rgb[f324 + 4]), 32'h01FE01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
